// File: rtl/rename_free_list_ckpt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rename_free_list_ckpt : N-way physical-register free list with head checkpoints
// Revision: 1.0
// ---------------------------------------------------------------------------
module rename_free_list_ckpt #(
   parameter  int N_WAY  = 2,
   parameter  int N_PR   = 64,
   parameter  int N_ARCH = 32,
   parameter  int N_CKPT = 4,
   localparam int TAG_W  = $clog2(N_PR),
   localparam int CK_W   = $clog2(N_CKPT),
   localparam int DEPTH  = N_PR - N_ARCH,
   localparam int PTR_W  = $clog2(DEPTH) + 1,
   localparam int NUM_W  = $clog2(N_WAY) + 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_W-1:0]       alloc_num,
   output logic [N_WAY*TAG_W-1:0] free_tag,
   output logic [NUM_W-1:0]       free_num,
   output logic [NUM_W-1:0]       alloc_granted,
   input  logic [N_WAY-1:0]       ret_valid,
   input  logic [N_WAY*TAG_W-1:0] ret_told,
   input  logic                   ckpt_take,
   input  logic [CK_W-1:0]        ckpt_wr_id,
   input  logic                   ckpt_restore,
   input  logic [CK_W-1:0]        ckpt_rd_id,
   output logic [PTR_W-1:0]       count,
   output logic                   overflow_err
);

   localparam int IDX_W = PTR_W - 1;

   logic [TAG_W-1:0] mem  [DEPTH];
   logic [PTR_W-1:0] ckpt [N_CKPT];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   logic [PTR_W-1:0] space;
   logic [PTR_W-1:0] n_push;
   logic [N_WAY-1:0] push_we;
   logic [IDX_W-1:0] push_idx [N_WAY];
   logic             push_drop;
   logic [PTR_W-1:0] head_alloc;

   assign count      = tail - head;
   assign head_alloc = head + PTR_W'(alloc_granted);

   always_comb begin
      if (count >= PTR_W'(N_WAY))
         free_num = NUM_W'(N_WAY);
      else
         free_num = NUM_W'(count);

      if (ckpt_restore)
         alloc_granted = '0;
      else if (alloc_num < free_num)
         alloc_granted = alloc_num;
      else
         alloc_granted = free_num;

      free_tag = '0;
      for (int i = 0; i < N_WAY; i++) begin
         if (NUM_W'(i) < free_num)
            free_tag[i*TAG_W +: TAG_W] = mem[IDX_W'(head + PTR_W'(i))];
      end
   end

   // Valid non-zero retire tags pack into consecutive slots from tail; any
   // lane that finds no room left is dropped and flagged.
   always_comb begin
      space     = PTR_W'(DEPTH) - count;
      n_push    = '0;
      push_we   = '0;
      push_drop = 1'b0;
      for (int i = 0; i < N_WAY; i++) begin
         push_idx[i] = '0;
         if (ret_valid[i] && (ret_told[i*TAG_W +: TAG_W] != '0)) begin
            if (n_push < space) begin
               push_we[i]  = 1'b1;
               push_idx[i] = IDX_W'(tail + n_push);
               n_push      = n_push + 1'b1;
            end else begin
               push_drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head         <= '0;
         tail         <= PTR_W'(DEPTH);
         overflow_err <= 1'b0;
         for (int k = 0; k < DEPTH; k++)
            mem[k] <= TAG_W'(N_ARCH + k);
         for (int c = 0; c < N_CKPT; c++)
            ckpt[c] <= '0;
      end else begin
         for (int i = 0; i < N_WAY; i++) begin
            if (push_we[i])
               mem[push_idx[i]] <= ret_told[i*TAG_W +: TAG_W];
         end
         tail <= tail + n_push;
         head <= ckpt_restore ? ckpt[ckpt_rd_id] : head_alloc;
         if (ckpt_take && !ckpt_restore)
            ckpt[ckpt_wr_id] <= head_alloc;
         if (push_drop)
            overflow_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rename_free_list_ckpt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rename_free_list_ckpt : directed self-checking bench for the free list
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rename_free_list_ckpt;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  alloc_num = '0;
   logic [11:0] free_tag;
   logic [1:0]  free_num;
   logic [1:0]  alloc_granted;
   logic [1:0]  ret_valid = '0;
   logic [11:0] ret_told = '0;
   logic        ckpt_take = 1'b0;
   logic [1:0]  ckpt_wr_id = '0;
   logic        ckpt_restore = 1'b0;
   logic [1:0]  ckpt_rd_id = '0;
   logic [5:0]  count;
   logic        overflow_err;

   int checks = 0;
   int errors = 0;

   rename_free_list_ckpt #(.N_WAY(2), .N_PR(64), .N_ARCH(32), .N_CKPT(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .alloc_num    (alloc_num),
      .free_tag     (free_tag),
      .free_num     (free_num),
      .alloc_granted(alloc_granted),
      .ret_valid    (ret_valid),
      .ret_told     (ret_told),
      .ckpt_take    (ckpt_take),
      .ckpt_wr_id   (ckpt_wr_id),
      .ckpt_restore (ckpt_restore),
      .ckpt_rd_id   (ckpt_rd_id),
      .count        (count),
      .overflow_err (overflow_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] pair(input int hi, input int lo);
      logic [5:0] h, l;
      h = 6'(hi);
      l = 6'(lo);
      return {20'd0, h, l};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset        = 1'b0;
      alloc_num    = '0;
      ret_valid    = '0;
      ret_told     = '0;
      ckpt_take    = 1'b0;
      ckpt_restore = 1'b0;
   endtask

   initial begin
      // reset asserted while other inputs are active must still win
      alloc_num = 2'd2;
      ret_valid = 2'b11;
      ret_told  = {6'd12, 6'd13};
      do_reset();
      #1;
      check("rst_tag",   32'(free_tag), pair(33, 32));
      check("rst_num",   32'(free_num), 2);
      check("rst_count", 32'(count), 32);
      check("rst_ovf",   32'(overflow_err), 0);
      check("rst_grant", 32'(alloc_granted), 0);

      // drain all 32 initial tags in order
      alloc_num = 2'd2;
      for (int i = 0; i < 16; i++) begin
         #1;
         check("drain_tag",   32'(free_tag), pair(33 + 2*i, 32 + 2*i));
         check("drain_grant", 32'(alloc_granted), 2);
         tick();
      end
      #1;
      check("empty_count", 32'(count), 0);
      check("empty_tag",   32'(free_tag), 0);
      check("empty_num",   32'(free_num), 0);
      check("empty_grant", 32'(alloc_granted), 0);

      // retire {5,7}; no bypass into the same cycle
      alloc_num = 2'd0;
      ret_valid = 2'b11;
      ret_told  = {6'd7, 6'd5};
      #1;
      check("nobypass_num", 32'(free_num), 0);
      tick();
      ret_valid = 2'b00;
      #1;
      check("ret57_tag",   32'(free_tag), pair(7, 5));
      check("ret57_count", 32'(count), 2);
      alloc_num = 2'd2;
      tick();

      // steady retire/allocate stream across the index wrap
      for (int j = 0; j < 20; j++) begin
         ret_valid = 2'b11;
         ret_told  = {6'(11 + 2*j), 6'(10 + 2*j)};
         #1;
         check("wrap_count", 32'(count), (j == 0) ? 0 : 2);
         check("wrap_grant", 32'(alloc_granted), (j == 0) ? 0 : 2);
         if (j != 0)
            check("wrap_tag", 32'(free_tag), pair(11 + 2*(j-1), 10 + 2*(j-1)));
         tick();
      end
      ret_valid = 2'b00;
      #1;
      check("wrap_last", 32'(free_tag), pair(49, 48));
      tick();
      alloc_num = 2'd0;
      #1;
      check("wrap_end_count", 32'(count), 0);

      // checkpoint: take at head=2 while granting 2 -> slot1 = 4
      do_reset();
      alloc_num = 2'd2;
      tick();
      ckpt_take  = 1'b1;
      ckpt_wr_id = 2'd1;
      tick();
      ckpt_take = 1'b0;
      tick();
      tick();
      tick();
      #1;
      check("ck_pre_count", 32'(count), 22);
      ckpt_restore = 1'b1;
      ckpt_rd_id   = 2'd1;
      #1;
      check("ck_rs_grant", 32'(alloc_granted), 0);
      tick();
      ckpt_restore = 1'b0;
      alloc_num    = 2'd0;
      #1;
      check("ck_rs_tag",   32'(free_tag), pair(37, 36));
      check("ck_rs_count", 32'(count), 28);

      // slot2 = 4, allocate 2, then restore with retire {9,0}
      ckpt_take  = 1'b1;
      ckpt_wr_id = 2'd2;
      tick();
      ckpt_take = 1'b0;
      alloc_num = 2'd2;
      tick();
      alloc_num    = 2'd0;
      ckpt_restore = 1'b1;
      ckpt_rd_id   = 2'd2;
      ret_valid    = 2'b11;
      ret_told     = {6'd0, 6'd9};
      tick();
      ckpt_restore = 1'b0;
      ret_valid    = 2'b00;
      #1;
      check("rsret_count", 32'(count), 29);
      check("rsret_tag",   32'(free_tag), pair(37, 36));

      // take + restore together: take into slot2 must be ignored
      alloc_num = 2'd2;
      tick();
      alloc_num    = 2'd0;
      ckpt_take    = 1'b1;
      ckpt_wr_id   = 2'd2;
      ckpt_restore = 1'b1;
      ckpt_rd_id   = 2'd1;
      tick();
      ckpt_take    = 1'b0;
      ckpt_restore = 1'b0;
      alloc_num    = 2'd2;
      tick();
      alloc_num    = 2'd0;
      ckpt_restore = 1'b1;
      ckpt_rd_id   = 2'd2;
      tick();
      ckpt_restore = 1'b0;
      #1;
      check("tkrs_tag",   32'(free_tag), pair(37, 36));
      check("tkrs_count", 32'(count), 29);
      check("tkrs_ovf",   32'(overflow_err), 0);

      // overflow when full, sticky until reset
      do_reset();
      ret_valid = 2'b11;
      ret_told  = {6'd13, 6'd12};
      tick();
      ret_valid = 2'b00;
      #1;
      check("ovf_set",   32'(overflow_err), 1);
      check("ovf_count", 32'(count), 32);
      check("ovf_tag",   32'(free_tag), pair(33, 32));
      alloc_num = 2'd2;
      tick();
      tick();
      #1;
      check("ovf_sticky", 32'(overflow_err), 1);
      check("ovf_cnt2",   32'(count), 28);
      do_reset();
      #1;
      check("ovf_clear", 32'(overflow_err), 0);

      // partial overflow: one free slot, two pushes
      alloc_num = 2'd1;
      tick();
      alloc_num = 2'd0;
      ret_valid = 2'b11;
      ret_told  = {6'd21, 6'd20};
      tick();
      ret_valid = 2'b00;
      #1;
      check("povf_ovf",   32'(overflow_err), 1);
      check("povf_count", 32'(count), 32);
      check("povf_tag",   32'(free_tag), pair(34, 33));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
